// File: rtl/jt10_adpcm_divn_pkg.sv
// Shared types for the multi-channel ADPCM divider: FSM state encoding and
// the channel-tag width helper.
package jt10_adpcm_divn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } div_st_e;

  // Channel tag width: at least one bit even for a single channel.
  function automatic int div_cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jt10_adpcm_divn_rr_arb.sv
// Round-robin arbiter for the shared divider: picks the first requesting
// channel at or after the pointer, which moves past each accepted grant.
module jt10_div_rr_arb
  import jt10_adpcm_divn_pkg::*;
#(
  parameter int  CH = 4,
  localparam int CW = div_cw(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [CH-1:0] req,
  input  logic          advance,
  output logic [CW-1:0] gnt,
  output logic          gnt_vld
);

  logic [CW-1:0]   ptr_q;
  logic [CW-1:0]   ptr_d;
  logic [2*CH-1:0] rot;
  logic            unused_rot_hi;
  int              off;
  int              idx;

  // Rotating a doubled copy puts the pointer channel at bit 0.
  assign rot           = {req, req} >> ptr_q;
  assign unused_rot_hi = ^rot[2*CH-1:CH];

  always_comb begin
    off     = 0;
    gnt_vld = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = i;
        gnt_vld = 1'b1;
      end
    end
    idx = int'(ptr_q) + off;
    if (idx >= CH) idx = idx - CH;
    gnt   = CW'(idx);
    ptr_d = (idx == CH - 1) ? '0 : CW'(idx + 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (cen && advance && gnt_vld) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/jt10_adpcm_divn.sv
// Shared multi-channel restoring divider (d=a/b, a=b*d+r), one quotient bit per cen.
// Define JT10_DIV_SIGNED_EN to honour per-channel sgn; otherwise all channels are unsigned.
module jt10_adpcm_divn
  import jt10_adpcm_divn_pkg::*;
#(
  parameter int  DW = 16,
  parameter int  CH = 4,
  localparam int CW = div_cw(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [CH-1:0]    start,
  input  logic [CH*DW-1:0] a,
  input  logic [CH*DW-1:0] b,
  input  logic [CH-1:0]    sgn,
  output logic [DW-1:0]    d,
  output logic [DW-1:0]    r,
  output logic             dz,
  output logic             done,
  output logic [CW-1:0]    done_ch,
  output logic [CH-1:0]    pend,
  output logic             working
);

  localparam int            NW     = $clog2(DW);
  localparam logic [DW-1:0] DZ_UNS = '1;
`ifdef JT10_DIV_SIGNED_EN
  localparam logic [DW-1:0] DZ_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DZ_NEG = {1'b1, {(DW-1){1'b0}}};
`endif

  div_st_e       st_q;
  logic [CH-1:0] req_q;
  logic [CH-1:0] req_d;
  logic [CW-1:0] cur_q;
  logic [NW-1:0] cnt_q;
  logic [DW-1:0] d_q, r_q;
  logic          dz_q, done_q;
  logic [CW-1:0] ch_q;

  logic [DW-1:0] ha_q [CH];
  logic [DW-1:0] hb_q [CH];
  logic [DW-1:0] wq_q, wr_q, wb_q, wa_q;
  logic          zero_q;
  logic [DW-1:0] wq_d, wr_d;
  logic [DW-1:0] sel_a, sel_b, ld_a, ld_b;
  logic [DW-1:0] fin_d, fin_r;
  logic [DW+1:0] sub;
  logic          unused_sub_msb;

  logic [CW-1:0] gnt;
  logic          gnt_vld;
  logic          adv;

  assign adv = (st_q == ST_IDLE) || (st_q == ST_DONE);

  jt10_div_rr_arb #(.CH(CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .req     (req_q),
    .advance (adv),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  // A grant consumes the request even if the same channel restarts on that edge:
  // LOAD then copies the freshly written holding regs, giving one result.
  always_comb begin
    req_d = req_q | start;
    if (adv && gnt_vld) req_d[gnt] = 1'b0;
  end

  always_comb begin
    pend = req_q;
    if (st_q != ST_IDLE) pend[cur_q] = 1'b1;
  end
  assign working = |pend;

  assign sel_a = ha_q[cur_q];
  assign sel_b = hb_q[cur_q];

`ifdef JT10_DIV_SIGNED_EN
  logic [CH-1:0] hs_q;
  logic          sel_s, neg_a, neg_b;
  logic          sg_q, qneg_q, rneg_q;

  assign sel_s = hs_q[cur_q];
  assign neg_a = sel_s & sel_a[DW-1];
  assign neg_b = sel_s & sel_b[DW-1];
  assign ld_a  = neg_a ? -sel_a : sel_a;
  assign ld_b  = neg_b ? -sel_b : sel_b;

  always_ff @(posedge clk) begin
    if (cen) begin
      for (int n = 0; n < CH; n++) begin
        if (start[n]) hs_q[n] <= sgn[n];
      end
      if (st_q == ST_LOAD) begin
        sg_q   <= sel_s;
        qneg_q <= neg_a ^ neg_b;
        rneg_q <= neg_a;
      end
    end
  end

  always_comb begin
    if (zero_q) begin
      fin_d = sg_q ? (wa_q[DW-1] ? DZ_NEG : DZ_POS) : DZ_UNS;
      fin_r = wa_q;
    end else begin
      fin_d = qneg_q ? -wq_q : wq_q;
      fin_r = rneg_q ? -wr_q : wr_q;
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = ^sgn;
  assign ld_a       = sel_a;
  assign ld_b       = sel_b;

  always_comb begin
    if (zero_q) begin
      fin_d = DZ_UNS;
      fin_r = wa_q;
    end else begin
      fin_d = wq_q;
      fin_r = wr_q;
    end
  end
`endif

  // Partial remainder is kept one bit wider so divisors above 2^(DW-1) still work.
  assign sub            = {1'b0, wr_q, wq_q[DW-1]} - {2'b00, wb_q};
  assign unused_sub_msb = sub[DW];

  always_comb begin
    if (!sub[DW+1]) begin
      wr_d = sub[DW-1:0];
      wq_d = {wq_q[DW-2:0], 1'b1};
    end else begin
      wr_d = {wr_q[DW-2:0], wq_q[DW-1]};
      wq_d = {wq_q[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (cen) begin
      for (int n = 0; n < CH; n++) begin
        if (start[n]) begin
          ha_q[n] <= a[n*DW +: DW];
          hb_q[n] <= b[n*DW +: DW];
        end
      end
      if (st_q == ST_LOAD) begin
        wq_q   <= ld_a;
        wr_q   <= '0;
        wb_q   <= ld_b;
        wa_q   <= sel_a;
        zero_q <= (sel_b == '0);
      end else if (st_q == ST_ITER) begin
        wq_q <= wq_d;
        wr_q <= wr_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      req_q  <= '0;
      cur_q  <= '0;
      cnt_q  <= '0;
      d_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      ch_q   <= '0;
    end else if (cen) begin
      req_q  <= req_d;
      done_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            cur_q <= gnt;
            st_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_q <= NW'(DW - 1);
          st_q  <= ST_ITER;
        end
        ST_ITER: begin
          if (cnt_q == '0) st_q  <= ST_DONE;
          else             cnt_q <= cnt_q - 1'b1;
        end
        ST_DONE: begin
          done_q <= 1'b1;
          d_q    <= fin_d;
          r_q    <= fin_r;
          dz_q   <= zero_q;
          ch_q   <= cur_q;
          if (gnt_vld) begin
            cur_q <= gnt;
            st_q  <= ST_LOAD;
          end else begin
            st_q <= ST_IDLE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign d       = d_q;
  assign r       = r_q;
  assign dz      = dz_q;
  assign done    = done_q;
  assign done_ch = ch_q;

endmodule

// File: tb/tb_jt10_adpcm_divn.sv
// Bench for jt10_adpcm_divn: directed cases plus randomized multi-channel traffic
// checked against an arithmetic reference and a pending/fairness scoreboard.
module tb_jt10_adpcm_divn;

  localparam int DW  = 16;
  localparam int CH  = 4;
  localparam int LIM = CH * (DW + 3) + 4;

  logic          clk = 1'b0;
  logic          rst, cen;
  logic [CH-1:0] start;
  logic [CH*DW-1:0] a, b;
  logic [CH-1:0] sgn;
  logic [DW-1:0] d, r;
  logic          dz, done;
  logic [1:0]    done_ch;
  logic [CH-1:0] pend;
  logic          working;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jt10_adpcm_divn #(.DW(DW), .CH(CH)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .a(a), .b(b), .sgn(sgn),
    .d(d), .r(r), .dz(dz), .done(done), .done_ch(done_ch), .pend(pend), .working(working)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic eff_sgn(input logic s);
`ifdef JT10_DIV_SIGNED_EN
    return s;
`else
    return s & 1'b0;
`endif
  endfunction

  // Reference: plain integer division with the documented b==0 and signed rules.
  function automatic void ref_div(input logic [15:0] av, input logic [15:0] bv, input logic s,
                                  output logic [15:0] q, output logic [15:0] rm, output logic z);
    longint sa, sb;
    z = (bv == 16'd0);
    if (!s) begin
      if (z) begin q = 16'hFFFF; rm = av; end
      else begin q = av / bv; rm = av % bv; end
    end else begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      if (z) begin q = (sa >= 0) ? 16'h7FFF : 16'h8000; rm = av; end
      else begin q = 16'(sa / sb); rm = 16'(sa % sb); end
    end
  endfunction

  task automatic check_res(input string tag, input int ch, input logic [15:0] av,
                           input logic [15:0] bv, input logic s);
    logic [15:0] eq, er;
    logic        ez;
    ref_div(av, bv, eff_sgn(s), eq, er, ez);
    chk_eq({tag, ".ch"}, 32'(done_ch), ch);
    chk_eq({tag, ".d"}, 32'(d), 32'(eq));
    chk_eq({tag, ".r"}, 32'(r), 32'(er));
    chk_eq({tag, ".dz"}, 32'(dz), 32'(ez));
  endtask

  task automatic post(input int ch, input logic [15:0] av, input logic [15:0] bv, input logic s);
    @(negedge clk);
    a[ch*DW +: DW] = av;
    b[ch*DW +: DW] = bv;
    sgn[ch]        = s;
    start          = '0;
    start[ch]      = 1'b1;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_done(input string tag, input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < maxc);
    if (!done) chk_eq({tag, ".timeout"}, 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [15:0] rnd_b();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'($urandom_range(1, 15));
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rnd_a();
    if ($urandom_range(0, 9) == 0) return 16'h8000;
    return 16'($urandom);
  endfunction

  int          cyc, k, first, seen;
  logic [15:0] oa [CH];
  logic [15:0] ob [CH];
  logic        os [CH];
  logic [CH-1:0] pend_after [3];

  // Scoreboard state for random traffic.
  logic [CH-1:0] mpend, nstart;
  logic [15:0]   ma [CH];
  logic [15:0]   mb [CH];
  logic          ms [CH];
  int            svc [CH];
  int            waitc [CH];
  logic          lastcen;
  int            c;

  initial begin
    rst = 1'b1; cen = 1'b1; start = '0; a = '0; b = '0; sgn = '0;
    idle(3);
    chk_eq("rst.d", 32'(d), 0);
    chk_eq("rst.r", 32'(r), 0);
    chk_eq("rst.dz", 32'(dz), 0);
    chk_eq("rst.done", 32'(done), 0);
    chk_eq("rst.done_ch", 32'(done_ch), 0);
    chk_eq("rst.pend", 32'(pend), 0);
    chk_eq("rst.working", 32'(working), 0);
    rst = 1'b0;
    idle(2);

    // Case 1: single unsigned request, no contention.
    post(0, 16'd1000, 16'd7, 1'b0);
    chk_eq("c1.pend", 32'(pend), 32'h1);
    chk_eq("c1.working", 32'(working), 1);
    wait_done("c1", 40, cyc);
    chk_eq("c1.lat", cyc, 19);
    chk_eq("c1.ch", 32'(done_ch), 0);
    chk_eq("c1.d", 32'(d), 142);
    chk_eq("c1.r", 32'(r), 6);
    chk_eq("c1.dz", 32'(dz), 0);
    chk_eq("c1.pend_clr", 32'(pend), 0);
    @(negedge clk);
    chk_eq("c1.pulse", 32'(done), 0);
    chk_eq("c1.d_hold", 32'(d), 142);
    idle(3);

    // Case 2: three simultaneous requests served in round-robin order.
    oa[1] = 16'd5000;  ob[1] = 16'd13;  os[1] = 1'b0;
    oa[2] = 16'd65535; ob[2] = 16'd255; os[2] = 1'b0;
    oa[3] = 16'd12345; ob[3] = 16'd1;   os[3] = 1'b0;
    pend_after[0] = 4'b1100; pend_after[1] = 4'b1000; pend_after[2] = 4'b0000;
    @(negedge clk);
    for (int n = 1; n < 4; n++) begin
      a[n*DW +: DW] = oa[n]; b[n*DW +: DW] = ob[n]; sgn[n] = os[n];
    end
    start = 4'b1110;
    @(negedge clk);
    start = '0;
    chk_eq("c2.pend", 32'(pend), 32'hE);
    k = 0; cyc = 0;
    while (k < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check_res($sformatf("c2.%0d", k), k + 1, oa[k+1], ob[k+1], os[k+1]);
        chk_eq($sformatf("c2.%0d.lat", k), cyc, 19 + 18 * k);
        chk_eq($sformatf("c2.%0d.pend", k), 32'(pend), 32'(pend_after[k]));
        k++;
      end
    end
    chk_eq("c2.count", k, 3);
    idle(3);

    // Case 3: divide by zero, same latency.
    post(2, 16'd100, 16'd0, 1'b0);
    wait_done("c3", 40, cyc);
    chk_eq("c3.lat", cyc, 19);
    chk_eq("c3.ch", 32'(done_ch), 2);
    chk_eq("c3.d", 32'(d), 32'hFFFF);
    chk_eq("c3.r", 32'(r), 100);
    chk_eq("c3.dz", 32'(dz), 1);
    idle(3);

`ifdef JT10_DIV_SIGNED_EN
    // Case 4: signed truncation and MIN/-1 wrap.
    post(1, 16'hFFF9, 16'd2, 1'b1);
    wait_done("c4a", 40, cyc);
    chk_eq("c4a.d", 32'(d), 32'hFFFD);
    chk_eq("c4a.r", 32'(r), 32'hFFFF);
    chk_eq("c4a.dz", 32'(dz), 0);
    idle(2);
    post(1, 16'h8000, 16'hFFFF, 1'b1);
    wait_done("c4b", 40, cyc);
    chk_eq("c4b.d", 32'(d), 32'h8000);
    chk_eq("c4b.r", 32'(r), 0);
    chk_eq("c4b.dz", 32'(dz), 0);
    idle(3);
`endif

    // Case 5: cen toggling halves the rate; done holds while cen is low.
    @(negedge clk);
    a[0 +: DW] = 16'd1000; b[0 +: DW] = 16'd7; sgn[0] = 1'b0;
    start = 4'b0001; cen = 1'b1;
    first = -1;
    for (int kk = 0; kk < 46; kk++) begin
      @(negedge clk);
      start = '0;
      if (done && first < 0) begin
        first = kk;
        chk_eq("c5.ch", 32'(done_ch), 0);
        chk_eq("c5.d", 32'(d), 142);
        chk_eq("c5.r", 32'(r), 6);
      end
      if (kk == 39) chk_eq("c5.done_hold", 32'(done), 1);
      if (kk == 40) chk_eq("c5.done_clr", 32'(done), 0);
      cen = ((kk + 1) % 2 == 0);
    end
    cen = 1'b1;
    chk_eq("c5.lat", first, 38);
    idle(3);

    // Case 6: reset in the middle of an iteration.
    post(0, 16'd50000, 16'd3, 1'b0);
    idle(8);
    rst = 1'b1;
    #1;
    chk_eq("c6.pend", 32'(pend), 0);
    chk_eq("c6.working", 32'(working), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk_eq("c6.no_done", seen, 0);
    chk_eq("c6.pend_idle", 32'(pend), 0);
    post(0, 16'd60001, 16'd77, 1'b0);
    wait_done("c6b", 40, cyc);
    chk_eq("c6b.lat", cyc, 19);
    check_res("c6b", 0, 16'd60001, 16'd77, 1'b0);
    idle(3);

    // Random traffic with random cen against the scoreboard.
    mpend = '0; nstart = '0; start = '0; cen = 1'b1; lastcen = 1'b1;
    for (int n = 0; n < CH; n++) begin svc[n] = 0; waitc[n] = 0; end
    for (int t = 0; t < 3400; t++) begin
      @(negedge clk);
      if (done && lastcen) begin
        c = int'(done_ch);
        chk_eq("rnd.ch_pending", 32'(mpend[c]), 1);
        check_res("rnd", c, ma[c], mb[c], ms[c]);
        chk_eq("rnd.rr_fair", 32'(svc[c] <= CH - 1), 1);
        chk_eq("rnd.latency", 32'(waitc[c] <= LIM), 1);
        for (int n = 0; n < CH; n++) if (n != c && mpend[n]) svc[n]++;
        mpend[c] = 1'b0;
      end
      if (lastcen) begin
        for (int n = 0; n < CH; n++) if (mpend[n]) waitc[n]++;
        for (int n = 0; n < CH; n++) begin
          if (nstart[n]) begin
            mpend[n] = 1'b1; svc[n] = 0; waitc[n] = 0;
          end
        end
      end
      chk_eq("rnd.pend", 32'(pend), 32'(mpend));
      chk_eq("rnd.working", 32'(working), 32'(|mpend));
      nstart = '0;
      if (t < 3000) begin
        for (int n = 0; n < CH; n++) begin
          if (!mpend[n] && $urandom_range(0, 99) < 6) begin
            nstart[n] = 1'b1;
            ma[n] = rnd_a(); mb[n] = rnd_b(); ms[n] = 1'($urandom_range(0, 1));
            a[n*DW +: DW] = ma[n]; b[n*DW +: DW] = mb[n]; sgn[n] = ms[n];
          end
        end
        cen = ($urandom_range(0, 9) != 0);
      end else begin
        cen = 1'b1;
      end
      start   = nstart;
      lastcen = cen;
    end
    start = '0;
    cen   = 1'b1;
    @(negedge clk);
    chk_eq("drain.pend", 32'(pend), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
